// File: rtl/demux_1_4_4b_pkg.sv
// Shared 4-bit datapath constants for the demux and its slot/mux helpers.
// Also holds the one-hot destination decode used by the top.
package demux_1_4_4b_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int DEST_COUNT = 4;
    localparam int SEL_WIDTH  = 2;

    typedef logic [SEL_WIDTH-1:0]  sel_t;
    typedef logic [DEST_COUNT-1:0] dest_mask_t;

    function automatic dest_mask_t decodeSel(input sel_t sel);
        dest_mask_t w_hot;
        w_hot = '0;
        w_hot[sel] = 1'b1;
        return w_hot;
    endfunction

endpackage

// File: rtl/demux_slot_4b.sv
// One destination slot: a single-entry holding register with a full flag.
// A load may coincide with an ack, so the slot refills without a bubble.
module demux_slot_4b
    import demux_1_4_4b_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ack,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ready
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Load wins over drain; an ack on an empty slot simply falls through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (r_full && i_ack) begin
            r_full <= 1'b0;
        end
    end

    assign o_ready = ~r_full | i_ack;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/mux4_1b.sv
// Plain 4:1 single-bit multiplexer.
module mux4_1b
    import demux_1_4_4b_pkg::*;
(
    input  logic [3:0] i_data,
    input  sel_t       i_sel,
    output logic       o_data
);

    always_comb begin
        o_data = 1'b0;
        case (i_sel)
            2'd0:    o_data = i_data[0];
            2'd1:    o_data = i_data[1];
            2'd2:    o_data = i_data[2];
            default: o_data = i_data[3];
        endcase
    end

endmodule

// File: rtl/demux_1_4_4b.sv
// 1-to-4 demultiplexer with a one-word holding slot per destination.
// The top decodes the select, picks the addressed slot's ready and fans out loads.
module demux_1_4_4b
    import demux_1_4_4b_pkg::*;
#(
    parameter int WIDTH    = DATA_WIDTH,
    parameter int NUM_DEST = DEST_COUNT
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic             busy
);

    logic [NUM_DEST-1:0] w_selHot;
    logic [NUM_DEST-1:0] w_load;
    logic [NUM_DEST-1:0] w_slotFull;
    logic [NUM_DEST-1:0] w_slotReady;
    logic [WIDTH-1:0]    w_slotData [NUM_DEST];
    logic                w_accept;

    assign w_selHot = decodeSel(in_sel);
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_selHot & {NUM_DEST{w_accept}};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEST; gi++) begin : g_slot
            demux_slot_4b #(.WIDTH(WIDTH)) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[gi]),
                .i_data  (in_data),
                .i_ack   (out_ack[gi]),
                .o_full  (w_slotFull[gi]),
                .o_data  (w_slotData[gi]),
                .o_ready (w_slotReady[gi])
            );
        end
    endgenerate

    // Ready depends only on the addressed slot, never on in_valid.
    mux4_1b u_readyMux (
        .i_data (w_slotReady),
        .i_sel  (in_sel),
        .o_data (in_ready)
    );

    assign out_data0 = w_slotData[0];
    assign out_data1 = w_slotData[1];
    assign out_data2 = w_slotData[2];
    assign out_data3 = w_slotData[3];
    assign out_valid = w_slotFull;
    assign busy      = |w_slotFull;

endmodule

// File: doc/demux_1_4_4b.md
DEMUX_1_4_4B -- requirements
Module: demux_1_4_4b

Interface
REQ-001 Parameter WIDTH, default 4, data width of every path.
REQ-002 Parameter NUM_DEST, default 4, number of destinations; fixed at 4, so sel is 2 bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  WIDTH  word to route.
REQ-006 in_sel  input  2  destination index 0..3.
REQ-007 in_valid  input  1  source offers in_data/in_sel this cycle.
REQ-008 in_ready  output  1  block accepts the offered word this cycle.
REQ-009 out_data0..out_data3  output  WIDTH each  per-destination held word.
REQ-010 out_valid  output  4  bit i set: out_data<i> holds an undelivered word.
REQ-011 out_ack  input  4  bit i set: destination i consumes its word this cycle.
REQ-012 busy  output  1  OR of out_valid.

Function
REQ-013 Each destination i owns a one-entry slot: full flag plus WIDTH-bit data register.
REQ-014 Transfer in: accept = in_valid AND in_ready, sampled at the rising edge.
REQ-015 in_ready = NOT full[in_sel] OR out_ack[in_sel]; combinational; independent of in_valid.
REQ-016 On accept, slot[in_sel] data <= in_data and full[in_sel] <= 1; out_valid[in_sel] rises one cycle after the accepting edge (latency 1).
REQ-017 Transfer out: when full[i] AND out_ack[i], full[i] <= 0 at that edge.
REQ-018 Simultaneous ack of slot i and accept into slot i: new data loaded, full[i] stays 1, no bubble.
REQ-019 out_ack[i] while full[i]=0 is ignored.
REQ-020 out_data<i> is stable while out_valid[i]=1 and keeps the last delivered word after drain; never changes except on accept into slot i.
REQ-021 Accept into slot i never alters any other slot's data or full flag.
REQ-022 Acks on several destinations in one cycle all take effect independently.
REQ-023 in_valid=1 with in_ready=0: no state change; the source holds in_data and in_sel stable until accepted.
REQ-024 in_sel and in_data are don't-care while in_valid=0; they have no effect on state.
REQ-025 busy = |out_valid, combinational from the full flags.

Reset
REQ-026 rst_n=0 at a rising edge: all full flags 0, all data registers 0. Takes priority over a simultaneous accept or ack.
REQ-027 Outputs after reset: out_valid=4'b0000, out_data0..3=0, busy=0, in_ready=1.
REQ-028 Reset mid-operation discards pending words without delivery; the first accept after rst_n returns to 1 behaves as from power-up.

Structure
REQ-029 WIDTH and NUM_DEST defaults belong in the shared cpu constants package, alongside the other 4-bit datapath widths.
REQ-030 One sub-module, demux_slot_4b (one slot: data register, full flag, load/ack logic), instantiated four times; the top holds sel decode and in_ready muxing.
REQ-031 The in_ready path is a 4:1 select of per-slot ready terms by in_sel, built with the existing 4:1 one-bit mux block.

Verification
REQ-032 Reset, then in_valid=1, in_sel=2, in_data=4'hA for one cycle -> next cycle out_valid=4'b0100, out_data2=4'hA, busy=1; other outputs 0.
REQ-033 Slot 1 full with 4'h3, no ack; offer in_sel=1, in_data=4'h7 -> in_ready=0, out_data1 stays 4'h3. Then assert out_ack[1] in the same cycle -> in_ready=1; next cycle out_data1=4'h7, out_valid[1]=1.
REQ-034 Fill slots 0..3 with 4'h1..4'h4 back to back -> out_valid=4'b1111 after the 4th edge. Then out_ack=4'b1111 for one cycle -> out_valid=0 and data still 4'h1..4'h4.
REQ-035 out_ack=4'b1111 with all slots empty -> no change; out_valid stays 0.
REQ-036 Slots 0 and 3 full, rst_n=0 for one edge while in_valid=1 to slot 2 -> all outputs 0 after that edge, in_ready=1, no word appears in slot 2.
REQ-037 Random in_sel/in_data/out_ack traffic against a four-queue reference model -> no word lost, duplicated or misrouted; out_data stable while valid.
